// File: rtl/quad_pkg.sv
// Shared types, Gray-code constants and the step classifier for the quadrature decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} qd_state_e;

    typedef enum logic [1:0] {NONE, INC, DEC, ERR} qd_dir_e;

    localparam logic [1:0] QD_S0 = 2'b00;
    localparam logic [1:0] QD_S1 = 2'b01;
    localparam logic [1:0] QD_S2 = 2'b11;
    localparam logic [1:0] QD_S3 = 2'b10;

    function automatic logic [1:0] qd_next_fwd(input logic [1:0] code);
        case (code)
            QD_S0:   return QD_S1;
            QD_S1:   return QD_S2;
            QD_S2:   return QD_S3;
            default: return QD_S0;
        endcase
    endfunction

    // Both bits flipping at once cannot be a legal single step of a Gray sequence.
    function automatic qd_dir_e qd_dir(input logic [1:0] prev, input logic [1:0] cur);
        if (cur == prev)
            return NONE;
        if ((prev ^ cur) == 2'b11)
            return ERR;
        if (cur == qd_next_fwd(prev))
            return INC;
        return DEC;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: two-flop synchronizer followed by a stability filter that
// only moves its output after FILTER_CYCLES consecutive differing samples.
module quad_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic s_reset_n,
    input  logic pin,
    output logic filt
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // The qualifying sample both updates the output and clears the counter.
    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front-end: filtered A/B channels, Gray-code step decode, an INIT
// settling window after reset, and registered inc/dec/err strobes.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic s_reset_n,
    input  logic enable,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clr,
    output logic inc_en,
    output logic dec_en,
    output logic err,
    output logic err_sticky
);

    localparam int INIT_LEN = FILTER_CYCLES + 3;
    localparam int IW       = $clog2(INIT_LEN);

    logic          f_a;
    logic          f_b;
    logic [1:0]    cur;
    logic [1:0]    prev;
    logic [IW-1:0] init_cnt;
    qd_state_e     state;
    qd_state_e     state_nxt;
    qd_dir_e       dir;
    logic          inc_nxt;
    logic          dec_nxt;
    logic          err_nxt;

    quad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
        .clk       (clk),
        .s_reset_n (s_reset_n),
        .pin       (enc_a),
        .filt      (f_a)
    );

    quad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
        .clk       (clk),
        .s_reset_n (s_reset_n),
        .pin       (enc_b),
        .filt      (f_b)
    );

    assign cur = {f_a, f_b};
    assign dir = qd_dir(prev, cur);

    always_ff @(posedge clk) begin
        if (!s_reset_n)
            state <= INIT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!s_reset_n)
            init_cnt <= '0;
        else if (state == INIT && init_cnt != IW'(INIT_LEN - 1))
            init_cnt <= init_cnt + IW'(1);
    end

    // INIT covers the pipeline fill, so the first filtered code after reset never strobes.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == IW'(INIT_LEN - 1)) state_nxt = TRACK;
            default: state_nxt = TRACK;
        endcase
    end

    always_comb begin
        inc_nxt = 1'b0;
        dec_nxt = 1'b0;
        err_nxt = 1'b0;
        if (state == TRACK && enable) begin
            case (dir)
                INC:     inc_nxt = 1'b1;
                DEC:     dec_nxt = 1'b1;
                ERR:     err_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    // prev follows cur unconditionally so gated or illegal steps are never replayed.
    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            prev       <= QD_S0;
            inc_en     <= 1'b0;
            dec_en     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev   <= cur;
            inc_en <= inc_nxt;
            dec_en <= dec_nxt;
            err    <= err_nxt;
            if (err)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder with FILTER_CYCLES = 4.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int FC  = 4;
    localparam int LAT = FC + 3;

    logic clk = 1'b0;
    logic s_reset_n;
    logic enable;
    logic enc_a;
    logic enc_b;
    logic err_clr;
    logic inc_en;
    logic dec_en;
    logic err;
    logic err_sticky;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int incCnt, decCnt, errCnt, overlapCnt;
    int changeCyc, lastLatency;
    bit pending;

    quad_decoder #(.FILTER_CYCLES(FC)) dut (
        .clk        (clk),
        .s_reset_n  (s_reset_n),
        .enable     (enable),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .err_clr    (err_clr),
        .inc_en     (inc_en),
        .dec_en     (dec_en),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (inc_en) incCnt++;
        if (dec_en) decCnt++;
        if (err)    errCnt++;
        if ((inc_en && dec_en) || (err && (inc_en || dec_en))) overlapCnt++;
        if (pending && (inc_en || dec_en || err)) begin
            lastLatency = cyc - changeCyc;
            pending = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearCounts();
        incCnt = 0;
        decCnt = 0;
        errCnt = 0;
    endtask

    task automatic applyStimulus(input logic a, input logic b, input int hold, input bit checkLat);
        enc_a = a;
        enc_b = b;
        changeCyc = cyc;
        lastLatency = -1;
        pending = 1'b1;
        ticks(hold);
        pending = 1'b0;
        if (checkLat) checkOutput("latency", lastLatency, LAT);
    endtask

    initial begin
        s_reset_n = 1'b0;
        enable = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        err_clr = 1'b0;
        overlapCnt = 0;
        pending = 1'b0;
        lastLatency = -1;
        changeCyc = 0;
        clearCounts();

        // Reset with pins resting at 11
        ticks(3);
        checkOutput("rst_inc", int'(inc_en), 0);
        checkOutput("rst_dec", int'(dec_en), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_sticky", int'(err_sticky), 0);
        s_reset_n = 1'b1;
        clearCounts();
        ticks(6);
        checkOutput("init_len_in", int'(dut.state), int'(INIT));
        tick();
        checkOutput("init_len_out", int'(dut.state), int'(TRACK));
        ticks(13);
        checkOutput("init_inc", incCnt, 0);
        checkOutput("init_dec", decCnt, 0);
        checkOutput("init_err", errCnt, 0);

        // Walk forward to 00, then one full forward cycle
        applyStimulus(1'b1, 1'b0, 10, 1'b0);
        applyStimulus(1'b0, 1'b0, 10, 1'b0);
        clearCounts();
        applyStimulus(1'b0, 1'b1, 10, 1'b1);
        applyStimulus(1'b1, 1'b1, 10, 1'b1);
        applyStimulus(1'b1, 1'b0, 10, 1'b1);
        applyStimulus(1'b0, 1'b0, 10, 1'b1);
        checkOutput("fwd_inc", incCnt, 4);
        checkOutput("fwd_dec", decCnt, 0);
        checkOutput("fwd_err", errCnt, 0);

        // Two reverse cycles from 00
        clearCounts();
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b1, 1'b0, 10, 1'b0);
            applyStimulus(1'b1, 1'b1, 10, 1'b0);
            applyStimulus(1'b0, 1'b1, 10, 1'b0);
            applyStimulus(1'b0, 1'b0, 10, 1'b0);
        end
        checkOutput("rev_dec", decCnt, 8);
        checkOutput("rev_inc", incCnt, 0);

        // 3-cycle glitch on A is rejected; a 4-cycle pulse just qualifies
        clearCounts();
        enc_a = 1'b1; ticks(3); enc_a = 1'b0; ticks(15);
        checkOutput("glitch3_inc", incCnt, 0);
        checkOutput("glitch3_dec", decCnt, 0);
        checkOutput("glitch3_err", errCnt, 0);
        enc_a = 1'b1; ticks(4); enc_a = 1'b0; ticks(20);
        checkOutput("pulse4_dec", decCnt, 1);
        checkOutput("pulse4_inc", incCnt, 1);

        // Illegal 01 -> 10 and sticky clear
        applyStimulus(1'b0, 1'b1, 10, 1'b0);
        clearCounts();
        applyStimulus(1'b1, 1'b0, 10, 1'b1);
        checkOutput("illegal_err", errCnt, 1);
        checkOutput("illegal_inc", incCnt, 0);
        checkOutput("illegal_dec", decCnt, 0);
        checkOutput("illegal_sticky", int'(err_sticky), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checkOutput("clr_sticky", int'(err_sticky), 0);
        tick();

        // err_clr coinciding with the err strobe: set wins
        enc_a = 1'b0;
        enc_b = 1'b1;
        ticks(LAT - 1);
        checkOutput("err_early", int'(err), 0);
        tick();
        checkOutput("err_strobe", int'(err), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checkOutput("set_wins", int'(err_sticky), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checkOutput("clr_again", int'(err_sticky), 0);
        ticks(5);

        // Disabled steps are tracked silently and never replayed
        clearCounts();
        enable = 1'b0;
        applyStimulus(1'b1, 1'b1, 10, 1'b0);
        applyStimulus(1'b1, 1'b0, 10, 1'b0);
        applyStimulus(1'b0, 1'b0, 10, 1'b0);
        enable = 1'b1;
        ticks(5);
        checkOutput("dis_inc", incCnt, 0);
        checkOutput("dis_dec", decCnt, 0);
        checkOutput("dis_err", errCnt, 0);
        applyStimulus(1'b0, 1'b1, 10, 1'b1);
        checkOutput("reen_inc", incCnt, 1);

        // Reset one edge before a strobe would have appeared
        enc_a = 1'b1;
        enc_b = 1'b1;
        ticks(LAT - 1);
        s_reset_n = 1'b0;
        tick();
        s_reset_n = 1'b1;
        checkOutput("midrst_inc", int'(inc_en), 0);
        checkOutput("midrst_dec", int'(dec_en), 0);
        checkOutput("midrst_err", int'(err), 0);
        checkOutput("midrst_state", int'(dut.state), int'(INIT));
        clearCounts();
        ticks(30);
        checkOutput("post_rst_inc", incCnt, 0);
        checkOutput("post_rst_err", errCnt, 0);
        checkOutput("post_rst_sticky", int'(err_sticky), 0);
        applyStimulus(1'b1, 1'b0, 10, 1'b1);
        checkOutput("post_rst_step", incCnt, 1);

        checkOutput("exclusive", overlapCnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature encoder front-end for the Arty S7 designs: synchronizes and glitch-filters the two encoder pins (A/B), decodes Gray-code transitions, and emits single-cycle `inc_en` / `dec_en` strobes that drive the up/down counter's `inc_en` / `dec_en` inputs directly. Illegal double-edge transitions are reported as an error pulse and a sticky flag. The block sits between the board pins and the counter, in the same clock domain.

## Interface
- `FILTER_CYCLES`, default 4 — consecutive stable samples required before a filtered channel changes; legal range 1..255.
- `clk`  in  1  system clock.
- `s_reset_n`  in  1  synchronous reset, active-low.
- `enable`  in  1  when high, strobes and errors are reported; when low, tracking continues silently.
- `enc_a`  in  1  raw encoder channel A, asynchronous to `clk`.
- `enc_b`  in  1  raw encoder channel B, asynchronous to `clk`.
- `err_clr`  in  1  clears `err_sticky`.
- `inc_en`  out  1  one-cycle strobe per forward step.
- `dec_en`  out  1  one-cycle strobe per reverse step.
- `err`  out  1  one-cycle strobe on illegal transition.
- `err_sticky`  out  1  latched error, held until `err_clr`.

## Operation
- Synchronizer: 2-FF per channel; reset value 0.
- Filter, per channel: filtered output `f` (reset 0), stability counter (reset 0, width `$clog2(FILTER_CYCLES+1)`).
  - Synchronized input == `f`: counter cleared.
  - Input != `f`: counter increments. When the input has differed for `FILTER_CYCLES` consecutive cycles, `f` takes the input and the counter is cleared in the same cycle.
- Decoder: `cur = {f_a, f_b}`, `prev` register (reset 2'b00).
  - Forward sequence 00→01→11→10→00: `inc_en`. Reverse sequence: `dec_en`. x4 resolution; one strobe per edge.
  - `cur == prev`: no output.
  - Both bits differ (00↔11, 01↔10): `err` only, with no inc/dec. `prev` resynchronizes to `cur`.
  - `prev <= cur` every cycle in every state.
- FSM states:
  - INIT: entered on reset; outputs forced 0; lasts `FILTER_CYCLES+3` cycles (init counter), then goes to TRACK.
  - TRACK: strobes are gated by `enable`. If `enable` is low, `inc_en` / `dec_en` / `err` are 0, but `prev` still follows `cur`, so no step is replayed when `enable` rises.
- `err_sticky`: set by any `err`. `err_clr` clears it. If a set and a clear occur in the same cycle, set wins.
- `inc_en` and `dec_en` are never high together; `err` is never high together with either.
- Reset values: `inc_en`, `dec_en`, `err`, `err_sticky` = 0; state = INIT.
- Reset mid-operation: all state is discarded. An encoder resting at any code produces no strobe and no error after reset.

## Timing
- All outputs are registered.
- Latency from a pin change to its strobe is `FILTER_CYCLES+3` rising edges:
  - 2 edges of synchronizer,
  - `FILTER_CYCLES` edges of filter qualification,
  - 1 edge of decode register.
- Pulses shorter than `FILTER_CYCLES` cycles (after synchronization) are rejected.
- Maximum step rate: one step per `FILTER_CYCLES+1` cycles. Faster input aliases to `err` or missed steps; no ordering is guaranteed in that case.
- Strobe width is exactly 1 cycle. Back-to-back strobes occur only if steps arrive at the maximum rate.

## Structure
- Package `quad_pkg`:
  - state enum `{INIT, TRACK}`,
  - Gray-code constants `QD_S0=2'b00`, `QD_S1=2'b01`, `QD_S2=2'b11`, `QD_S3=2'b10`,
  - function `qd_dir(prev, cur)` returning NONE / INC / DEC / ERR.
- Sub-module `quad_filter`: synchronizer plus stability filter for one channel, parameter `FILTER_CYCLES`, instantiated twice.
- The top level holds the decoder, FSM, init counter and sticky error.

## Test plan
- Reset, `FILTER_CYCLES=4`, pins held at 11, `enable=1` → INIT for 7 cycles; no `inc_en` / `dec_en` / `err` at any time.
- Forward steps 00→01→11→10→00, each held 10 cycles → 4 `inc_en` pulses, each 1 cycle wide, each 7 edges after its pin change; `dec_en=0`.
- Reverse sequence from 00, 8 steps → 8 `dec_en` pulses; `inc_en=0`.
- 3-cycle glitch on `enc_a` while at 00 → no strobe; filtered A stays 0.
- Illegal 01→10 held 10 cycles → `err` 1 cycle, `err_sticky=1`, no inc/dec. Assert `err_clr` for 1 cycle → `err_sticky=0`. Simultaneous `err` and `err_clr` → `err_sticky=1`.
- `enable=0` during 3 forward steps → no strobes. Raise `enable`, then 1 further step → exactly 1 `inc_en`.
- `s_reset_n` low for 1 cycle mid-sequence → outputs 0 the next cycle, INIT re-entered.
